// File: rtl/bank_queue_scheduler.sv
// rtl/bank_queue_scheduler.sv - per-bank FIFO pop scheduler with row-hit priority and urgency override
module bank_queue_scheduler #(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RA_POS     = 20,
    parameter int RA_BITS    = 10,
    parameter int MAX_HITS   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_Q-1:0]            q_valid_i,
    input  logic [NUM_Q-1:0]            q_mid_i,
    input  logic [NUM_Q*DATA_WIDTH-1:0] q_data_i,
    output logic [NUM_Q-1:0]            q_pop_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [$clog2(NUM_Q)-1:0]    sel_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        row_switch_o,
    output logic [RA_BITS-1:0]          open_row_o
);

    localparam int SEL_W = $clog2(NUM_Q);
    localparam int HIT_W = $clog2(MAX_HITS + 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_Q - 1);
    localparam logic [HIT_W-1:0] MAX_HITS_C = HIT_W'(MAX_HITS);

    typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_ACTIVE} state_t;

    state_t               state, state_n;
    logic                 pend_valid;
    logic [SEL_W-1:0]     pend_sel;
    logic                 row_open;
    logic [HIT_W-1:0]     hit_cnt;
    logic [SEL_W-1:0]     rr_ptr;

    logic [DATA_WIDTH-1:0] head_data [NUM_Q];
    logic [RA_BITS-1:0]    head_row  [NUM_Q];

    logic                 urg_found, hit_found, any_found;
    logic [SEL_W-1:0]     urg_sel, hit_sel, any_sel, scan_idx;
    logic                 hit_allowed, cand_found, cand_hit;
    logic [SEL_W-1:0]     cand_sel;

    logic                 slot_free;
    logic                 pop_en, do_switch, inc_hit;
    logic [SEL_W-1:0]     pop_sel;

    assign slot_free = !valid_o || ready_i;

    // Split the flat FIFO head bus into per-queue words and row fields
    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            head_data[q] = q_data_i[q*DATA_WIDTH +: DATA_WIDTH];
            head_row[q]  = q_data_i[q*DATA_WIDTH + RA_POS +: RA_BITS];
        end
    end

    // Round-robin scans from rr_ptr for urgent, same-row and any-valid queues
    always_comb begin
        urg_found = 1'b0;
        hit_found = 1'b0;
        any_found = 1'b0;
        urg_sel   = '0;
        hit_sel   = '0;
        any_sel   = '0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_Q; k++) begin
            if (!urg_found && q_valid_i[scan_idx] && q_mid_i[scan_idx]) begin
                urg_found = 1'b1;
                urg_sel   = scan_idx;
            end
            if (!hit_found && q_valid_i[scan_idx] && (head_row[scan_idx] == open_row_o)) begin
                hit_found = 1'b1;
                hit_sel   = scan_idx;
            end
            if (!any_found && q_valid_i[scan_idx]) begin
                any_found = 1'b1;
                any_sel   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_SEL) ? '0 : scan_idx + 1'b1;
        end
    end

    // Priority: urgent, then capped row hit, then plain round-robin
    always_comb begin
        hit_allowed = row_open && (hit_cnt < MAX_HITS_C);
        cand_found  = any_found;
        if (urg_found) begin
            cand_sel = urg_sel;
        end else if (hit_found && hit_allowed) begin
            cand_sel = hit_sel;
        end else begin
            cand_sel = any_sel;
        end
        cand_hit = row_open && (head_row[cand_sel] == open_row_o);
    end

    // Next-state and pop/switch decisions
    always_comb begin
        state_n   = state;
        pop_en    = 1'b0;
        pop_sel   = cand_sel;
        do_switch = 1'b0;
        inc_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cand_found) begin
                    do_switch = 1'b1;
                    state_n   = S_SWITCH;
                end
            end
            S_SWITCH: begin
                state_n = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (pend_valid) begin
                    // The request that opened this row goes out before any new selection
                    if (slot_free && q_valid_i[pend_sel]) begin
                        pop_en  = 1'b1;
                        pop_sel = pend_sel;
                    end
                end else if (cand_found) begin
                    if (cand_hit) begin
                        if (slot_free) begin
                            pop_en  = 1'b1;
                            inc_hit = 1'b1;
                        end
                    end else begin
                        // Switching may overlap a stalled output word
                        do_switch = 1'b1;
                        state_n   = S_SWITCH;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One-hot pop strobe toward the FIFO grants
    always_comb begin
        q_pop_o = '0;
        if (pop_en) begin
            q_pop_o[pop_sel] = 1'b1;
        end
    end

    // State, row tracking and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pend_valid   <= 1'b0;
            pend_sel     <= '0;
            row_open     <= 1'b0;
            hit_cnt      <= '0;
            rr_ptr       <= '0;
            open_row_o   <= '0;
            row_switch_o <= 1'b0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            sel_o        <= '0;
        end else begin
            state        <= state_n;
            row_switch_o <= do_switch;
            if (do_switch) begin
                pend_valid <= 1'b1;
                pend_sel   <= cand_sel;
                open_row_o <= head_row[cand_sel];
            end else if (pop_en && pend_valid) begin
                pend_valid <= 1'b0;
            end
            if (state == S_SWITCH) begin
                row_open <= 1'b1;
                hit_cnt  <= '0;
            end else if (inc_hit && (hit_cnt < MAX_HITS_C)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (pop_en) begin
                data_o  <= head_data[pop_sel];
                sel_o   <= pop_sel;
                valid_o <= 1'b1;
                rr_ptr  <= (pop_sel == LAST_SEL) ? '0 : pop_sel + 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bank_queue_scheduler.sv
// tb/tb_bank_queue_scheduler.sv - self-checking bench for bank_queue_scheduler
module tb_bank_queue_scheduler;

    localparam int NQ   = 4;
    localparam int DW   = 32;
    localparam int MAXH = 4;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NQ-1:0]   q_valid_i = '0;
    logic [NQ-1:0]   q_mid_i = '0;
    logic [NQ*DW-1:0] q_data_i = '0;
    logic [NQ-1:0]   q_pop_o;
    logic [DW-1:0]   data_o;
    logic [1:0]      sel_o;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic            row_switch_o;
    logic [9:0]      open_row_o;

    bank_queue_scheduler #(
        .NUM_Q(NQ), .DATA_WIDTH(DW), .RA_POS(20), .RA_BITS(10), .MAX_HITS(MAXH)
    ) dut (
        .clk(clk), .rst(rst),
        .q_valid_i(q_valid_i), .q_mid_i(q_mid_i), .q_data_i(q_data_i),
        .q_pop_o(q_pop_o), .data_o(data_o), .sel_o(sel_o), .valid_o(valid_o),
        .ready_i(ready_i), .row_switch_o(row_switch_o), .open_row_o(open_row_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int         q;
        logic [9:0] row;
        logic [3:0] exp_pop;
        logic [1:0] exp_sel;
    } vec_t;

    exp_t        sb[$];
    int          ev_log[$];
    logic [31:0] mem [NQ][DEPTH];
    int          wr [NQ];
    int          rd [NQ];
    logic [NQ-1:0] mid_force;
    int          seq = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [NQ-1:0] smp_pop;
    logic          smp_sw, smp_valid;
    logic [9:0]    smp_row;
    logic [31:0]   smp_data;
    logic [1:0]    smp_sel;

    function automatic logic [31:0] mk(input int q, input logic [9:0] row, input int s);
        return {2'b00, row, 4'(q), 16'(s)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int q = 0; q < NQ; q++) begin
            q_valid_i[q]          = (wr[q] != rd[q]);
            q_mid_i[q]            = mid_force[q] && (wr[q] != rd[q]);
            q_data_i[q*DW +: DW]  = (wr[q] != rd[q]) ? mem[q][rd[q] % DEPTH] : '0;
        end
    endtask

    task automatic push(input int q, input logic [9:0] row, output logic [31:0] d);
        d = mk(q, row, seq);
        seq++;
        mem[q][wr[q] % DEPTH] = d;
        wr[q]++;
        refresh();
    endtask

    task automatic expect_out(input int q, input logic [31:0] d);
        exp_t e;
        e.sel  = 2'(q);
        e.data = d;
        sb.push_back(e);
    endtask

    // One clock: sample at negedge, check legality and scoreboard, then retire pops after the edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        smp_pop   = q_pop_o;
        smp_sw    = row_switch_o;
        smp_row   = open_row_o;
        smp_valid = valid_o;
        smp_data  = data_o;
        smp_sel   = sel_o;
        if (smp_sw) ev_log.push_back(100 + int'(smp_row));
        if (smp_pop != '0) begin
            check("pop_onehot", $countones(smp_pop), 1);
            check("pop_of_empty", smp_pop & ~q_valid_i, 0);
            check("pop_when_slot_busy", valid_o && !ready_i, 0);
            for (int q = 0; q < NQ; q++) if (smp_pop[q]) ev_log.push_back(q);
        end
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", data_o, 0);
            end else begin
                e = sb.pop_front();
                check("sb_data", data_o, e.data);
                check("sb_sel", sel_o, e.sel);
            end
        end
        @(posedge clk);
        #1;
        for (int q = 0; q < NQ; q++) if (smp_pop[q]) rd[q]++;
        refresh();
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(name, sb.size(), 0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int q = 0; q < NQ; q++) begin
            wr[q] = 0;
            rd[q] = 0;
        end
        mid_force = '0;
        sb.delete();
        ev_log.delete();
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tv [4];
        logic [31:0] d, d2, d3;
        logic [31:0] t4_d [11];
        int          n0, i, j;

        tv[0] = '{q: 0, row: 10'd5,   exp_pop: 4'b0001, exp_sel: 2'd0};
        tv[1] = '{q: 2, row: 10'h3FF, exp_pop: 4'b0100, exp_sel: 2'd2};
        tv[2] = '{q: 3, row: 10'd0,   exp_pop: 4'b1000, exp_sel: 2'd3};
        tv[3] = '{q: 1, row: 10'h155, exp_pop: 4'b0010, exp_sel: 2'd1};

        mid_force = '0;
        for (int q = 0; q < NQ; q++) begin
            wr[q] = 0;
            rd[q] = 0;
        end

        // T1: reset with every queue non-empty
        rst = 1'b1;
        for (int q = 0; q < NQ; q++) push(q, 10'(q + 1), d);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t1_reset_outputs", {q_pop_o, valid_o, row_switch_o}, 0);
        end
        do_reset();

        // T2: first access latency, table driven
        for (int v = 0; v < 4; v++) begin
            do_reset();
            ready_i = 1'b1;
            push(tv[v].q, tv[v].row, d);
            expect_out(tv[v].q, d);
            step();
            check("t2_no_switch_yet", {smp_sw, smp_pop}, 0);
            step();
            check("t2_c0_switch", smp_sw, 1);
            check("t2_c0_row", smp_row, tv[v].row);
            check("t2_c0_no_pop", smp_pop, 0);
            step();
            check("t2_c1_pop", smp_pop, tv[v].exp_pop);
            step();
            check("t2_c2_valid", smp_valid, 1);
            check("t2_c2_sel", smp_sel, tv[v].exp_sel);
            check("t2_c2_data", smp_data, d);
            run_until_empty(10, "t2_drain");
        end

        // T3: row hit wins over round-robin order
        do_reset();
        push(1, 10'd5, d);
        expect_out(1, d);
        run_until_empty(20, "t3_setup_drain");
        push(1, 10'd5, d2);
        push(2, 10'd7, d3);
        expect_out(1, d2);
        expect_out(2, d3);
        step();
        check("t3_hit_pop", smp_pop, 4'b0010);
        check("t3_no_switch", smp_sw, 0);
        run_until_empty(20, "t3_drain");

        // T4: hit cap forces a switch to the waiting row
        do_reset();
        for (int k = 0; k < 10; k++) push(0, 10'd5, t4_d[k]);
        push(1, 10'd7, t4_d[10]);
        for (int k = 0; k < 5; k++) expect_out(0, t4_d[k]);
        expect_out(1, t4_d[10]);
        for (int k = 5; k < 10; k++) expect_out(0, t4_d[k]);
        run_until_empty(100, "t4_drain");
        // row-opening pop plus MAX_HITS hits precede the switch
        n0 = 0;
        i = 0;
        while (i < ev_log.size() && ev_log[i] != 107) begin
            if (ev_log[i] == 0) n0++;
            i++;
        end
        check("t4_q0_pops_before_switch", n0, MAXH + 1);
        check("t4_switch_to_row7_seen", i < ev_log.size(), 1);
        j = i + 1;
        while (j < ev_log.size() && ev_log[j] >= 100) j++;
        check("t4_first_pop_after_switch", (j < ev_log.size()) ? ev_log[j] : -1, 1);

        // T5: urgent queue on another row preempts the open-row hit
        do_reset();
        push(0, 10'd5, d);
        expect_out(0, d);
        run_until_empty(20, "t5_setup_drain");
        ev_log.delete();
        mid_force[3] = 1'b1;
        push(0, 10'd5, d2);
        push(3, 10'd9, d3);
        expect_out(3, d3);
        expect_out(0, d2);
        run_until_empty(30, "t5_drain");
        mid_force[3] = 1'b0;
        check("t5_first_event_switch9", (ev_log.size() > 0) ? ev_log[0] : -1, 109);
        check("t5_first_pop_q3", (ev_log.size() > 1) ? ev_log[1] : -1, 3);
        check("t5_then_switch5", (ev_log.size() > 2) ? ev_log[2] : -1, 105);

        // T6: backpressure holds the output and blocks the pending hit
        ready_i = 1'b0;
        push(0, 10'd5, d);
        push(0, 10'd5, d2);
        expect_out(0, d);
        expect_out(0, d2);
        step();
        check("t6_first_pop", smp_pop, 4'b0001);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t6_hold_no_pop", smp_pop, 0);
            check("t6_hold_data", {smp_valid, smp_data}, {1'b1, d});
        end
        ready_i = 1'b1;
        step();
        check("t6_release_pop", smp_pop, 4'b0001);
        step();
        check("t6_new_data", {smp_valid, smp_data}, {1'b1, d2});
        run_until_empty(10, "t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
